// File: rtl/return_stack_if.sv
// return_stack_if: strobes, data and status bundle for the return-address stack.
// master = stack user (fetch/decider side), slave = return_stack itself.
interface return_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             STACK_PUSH;
  logic             STACK_POP;
  logic [WIDTH-1:0] PUSH_data;
  logic             ERR_CLR;
  logic [WIDTH-1:0] POP_output;
  logic             STACK_EMPTY;
  logic             STACK_FULL;
  logic [CW-1:0]    STACK_COUNT;
  logic             STACK_OVF;
  logic             STACK_UNF;

  modport master (
    output STACK_PUSH,
    output STACK_POP,
    output PUSH_data,
    output ERR_CLR,
    input  POP_output,
    input  STACK_EMPTY,
    input  STACK_FULL,
    input  STACK_COUNT,
    input  STACK_OVF,
    input  STACK_UNF
  );

  modport slave (
    input  STACK_PUSH,
    input  STACK_POP,
    input  PUSH_data,
    input  ERR_CLR,
    output POP_output,
    output STACK_EMPTY,
    output STACK_FULL,
    output STACK_COUNT,
    output STACK_OVF,
    output STACK_UNF
  );
endinterface

// File: rtl/return_stack.sv
// return_stack: LIFO of return addresses with combinational top-of-stack read.
// Sticky overflow/underflow flags are built only with RETURN_STACK_ERR_FLAGS_EN.
module return_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input logic          clk,
  input logic          rst,
  return_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] LP_ONE   = CW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_cnt;

  logic             w_empty;
  logic             w_full;
  logic [CW-1:0]    w_cnt_m1;
  logic [AW-1:0]    w_top_idx;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_ovf_evt;
  logic             w_unf_evt;

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == LP_DEPTH);
  assign w_cnt_m1  = r_cnt - LP_ONE;
  assign w_top_idx = w_cnt_m1[AW-1:0];

  // Decode push/pop into write, next occupancy and error events.
  always_comb begin
    w_we      = 1'b0;
    w_waddr   = w_top_idx;
    w_cnt_nxt = r_cnt;
    w_ovf_evt = 1'b0;
    w_unf_evt = 1'b0;
    unique case ({bus.STACK_PUSH, bus.STACK_POP})
      2'b10: begin
        if (w_full) begin
          w_ovf_evt = 1'b1;
        end else begin
          w_we      = 1'b1;
          w_waddr   = r_cnt[AW-1:0];
          w_cnt_nxt = r_cnt + LP_ONE;
        end
      end
      2'b01: begin
        if (w_empty) begin
          w_unf_evt = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_m1;
        end
      end
      2'b11: begin
        w_we = 1'b1;
        if (w_empty) begin
          // Pop half finds nothing; the push half still lands.
          w_waddr   = '0;
          w_cnt_nxt = LP_ONE;
          w_unf_evt = 1'b1;
        end else begin
          // Replace top: tail call / return-then-call.
          w_waddr = w_top_idx;
        end
      end
      default: begin
        w_we = 1'b0;
      end
    endcase
  end

  // Storage array; contents survive reset, writes suppressed during it.
  always_ff @(posedge clk) begin
    if (!rst && w_we) begin
      r_mem[w_waddr] <= bus.PUSH_data;
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

`ifdef RETURN_STACK_ERR_FLAGS_EN
  logic r_ovf;
  logic r_unf;

  // Sticky error flags; a new event beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end else if (bus.ERR_CLR) begin
        r_ovf <= 1'b0;
      end
      if (w_unf_evt) begin
        r_unf <= 1'b1;
      end else if (bus.ERR_CLR) begin
        r_unf <= 1'b0;
      end
    end
  end

  assign bus.STACK_OVF = r_ovf;
  assign bus.STACK_UNF = r_unf;
`else
  logic w_unused;

  assign w_unused      = ^{bus.ERR_CLR, w_ovf_evt, w_unf_evt};
  assign bus.STACK_OVF = 1'b0;
  assign bus.STACK_UNF = 1'b0;
`endif

  assign bus.POP_output  = w_empty ? '0 : r_mem[w_top_idx];
  assign bus.STACK_EMPTY = w_empty;
  assign bus.STACK_FULL  = w_full;
  assign bus.STACK_COUNT = r_cnt;
endmodule

// File: tb/tb_return_stack.sv
// tb_return_stack: directed plan plus random mix against a queue model.
// Expected flag values follow RETURN_STACK_ERR_FLAGS_EN.
module tb_return_stack;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk;
  logic rst;

  return_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] q [$];
  bit m_ovf;
  bit m_unf;

`ifdef RETURN_STACK_ERR_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [WIDTH-1:0] top;
    top = (q.size() > 0) ? q[q.size()-1] : '0;
    check({tag, ".top"},   32'(bus.POP_output),  32'(top));
    check({tag, ".count"}, 32'(bus.STACK_COUNT), 32'(q.size()));
    check({tag, ".empty"}, 32'(bus.STACK_EMPTY), 32'(q.size() == 0));
    check({tag, ".full"},  32'(bus.STACK_FULL),  32'(q.size() == DEPTH));
    check({tag, ".ovf"},   32'(bus.STACK_OVF),   32'(m_ovf & FLAGS_EN));
    check({tag, ".unf"},   32'(bus.STACK_UNF),   32'(m_unf & FLAGS_EN));
  endtask

  task automatic model(input bit p, input bit o, input logic [WIDTH-1:0] d,
                       input bit c, input bit r);
    bit oe;
    bit ue;
    oe = 1'b0;
    ue = 1'b0;
    if (r) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (p && !o) begin
        if (q.size() == DEPTH) oe = 1'b1;
        else q.push_back(d);
      end else if (!p && o) begin
        if (q.size() == 0) ue = 1'b1;
        else void'(q.pop_back());
      end else if (p && o) begin
        if (q.size() == 0) begin
          q.push_back(d);
          ue = 1'b1;
        end else begin
          q[q.size()-1] = d;
        end
      end
      if (oe) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      if (ue) m_unf = 1'b1;
      else if (c) m_unf = 1'b0;
    end
  endtask

  task automatic step(input string tag, input bit p, input bit o,
                      input logic [WIDTH-1:0] d, input bit c, input bit r);
    bus.STACK_PUSH = p;
    bus.STACK_POP  = o;
    bus.PUSH_data  = d;
    bus.ERR_CLR    = c;
    rst            = r;
    @(posedge clk);
    model(p, o, d, c, r);
    #1;
    bus.STACK_PUSH = 1'b0;
    bus.STACK_POP  = 1'b0;
    bus.ERR_CLR    = 1'b0;
    rst            = 1'b0;
    check_all(tag);
  endtask

  initial begin
    bit p;
    bit o;
    bit c;
    bit r;
    logic [WIDTH-1:0] d;
    bus.STACK_PUSH = 1'b0;
    bus.STACK_POP  = 1'b0;
    bus.PUSH_data  = '0;
    bus.ERR_CLR    = 1'b0;
    rst            = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #2;

    step("reset", 0, 0, 16'h0, 0, 1);
    check("reset.top_const", 32'(bus.POP_output), 32'h0);
    check("reset.empty_const", 32'(bus.STACK_EMPTY), 32'h1);

    step("push1", 1, 0, 16'h0010, 0, 0);
    step("push2", 1, 0, 16'h0020, 0, 0);
    step("push3", 1, 0, 16'h0030, 0, 0);
    check("lifo.cnt3", 32'(bus.STACK_COUNT), 32'd3);
    check("lifo.top30", 32'(bus.POP_output), 32'h0030);
    step("pop1", 0, 1, 16'h0, 0, 0);
    check("lifo.top20", 32'(bus.POP_output), 32'h0020);
    step("pop2", 0, 1, 16'h0, 0, 0);
    check("lifo.top10", 32'(bus.POP_output), 32'h0010);
    step("pop3", 0, 1, 16'h0, 0, 0);
    check("lifo.top0", 32'(bus.POP_output), 32'h0000);

    for (int i = 0; i < DEPTH; i++)
      step("fill", 1, 0, 16'(16'h0100 + i), 0, 0);
    check("full.flag", 32'(bus.STACK_FULL), 32'h1);
    step("ovf_push", 1, 0, 16'h0BAD, 0, 0);
    check("ovf.top", 32'(bus.POP_output), 32'h0107);
    check("ovf.flag", 32'(bus.STACK_OVF), 32'(FLAGS_EN));

    step("rst2", 0, 0, 16'h0, 0, 1);
    step("unf_pop", 0, 1, 16'h0, 0, 0);
    check("unf.flag", 32'(bus.STACK_UNF), 32'(FLAGS_EN));
    step("errclr", 0, 0, 16'h0, 1, 0);
    check("unf.cleared", 32'(bus.STACK_UNF), 32'h0);
    step("unf_vs_clr", 0, 1, 16'h0, 1, 0);
    check("unf.wins", 32'(bus.STACK_UNF), 32'(FLAGS_EN));
    step("both_empty", 1, 1, 16'h0066, 1, 0);
    check("both_empty.cnt", 32'(bus.STACK_COUNT), 32'd1);

    step("rst3", 0, 0, 16'h0, 0, 1);
    step("rp1", 1, 0, 16'h0010, 0, 0);
    step("rp2", 1, 0, 16'h0020, 0, 0);
    step("repl", 1, 1, 16'h0055, 0, 0);
    check("repl.top", 32'(bus.POP_output), 32'h0055);
    check("repl.cnt", 32'(bus.STACK_COUNT), 32'd2);
    for (int i = 2; i < DEPTH; i++)
      step("fill2", 1, 0, 16'(16'h0200 + i), 0, 0);
    step("repl_full", 1, 1, 16'h0077, 0, 0);
    check("repl_full.ovf", 32'(bus.STACK_OVF), 32'h0);
    check("repl_full.top", 32'(bus.POP_output), 32'h0077);

    step("rst4", 0, 0, 16'h0, 0, 1);
    step("pa", 1, 0, 16'h0011, 0, 0);
    step("pb", 1, 0, 16'h0022, 0, 0);
    step("rst_push", 1, 0, 16'h0077, 0, 1);
    check("rst_push.cnt", 32'(bus.STACK_COUNT), 32'd0);
    step("post_rst", 1, 0, 16'h0042, 0, 0);
    check("post_rst.top", 32'(bus.POP_output), 32'h0042);

    for (int i = 0; i < 2000; i++) begin
      int bias;
      bias = (i / 100) % 3;
      p = ($urandom_range(0, 9) < 3 + 2 * bias);
      o = ($urandom_range(0, 9) < 7 - 2 * bias);
      d = 16'($urandom);
      c = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 249) == 0);
      step("rand", p, o, d, c, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/return_stack.md
# return_stack

Hardware LIFO of 16-bit return addresses that supplies the `POP_input` of the PC input decider. A call pushes the return address; a return pops it, and the top-of-stack value is presented combinationally so the decider can load it into the PC in the same cycle as `STACK_POP`. The block tracks occupancy, exposes full/empty status, and optionally records overflow/underflow errors.

## Interface
- `WIDTH`, 16, address width in bits.
- `DEPTH`, 8, number of entries; power of two, minimum 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `STACK_PUSH`  in  1  push `PUSH_data` this cycle.
- `STACK_POP`  in  1  pop the top of stack this cycle; the same strobe drives the PC input decider.
- `PUSH_data`  in  WIDTH  return address to push (PC+1 of the call).
- `ERR_CLR`  in  1  clears the sticky error flags.
- `POP_output`  out  WIDTH  current top of stack; connects to the decider's `POP_input`.
- `STACK_EMPTY`  out  1  occupancy == 0.
- `STACK_FULL`  out  1  occupancy == DEPTH.
- `STACK_COUNT`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `STACK_OVF`  out  1  sticky: a push was attempted while full.
- `STACK_UNF`  out  1  sticky: a pop was attempted while empty.

## Operation
- Storage: `DEPTH` x `WIDTH` register array plus an occupancy counter `cnt`. The top entry is `mem[cnt-1]`.
- `POP_output` = `mem[cnt-1]` when `cnt` > 0, otherwise all zeros. This is a combinational read from registered state.
- Push only (`PUSH`=1, `POP`=0):
  - not full: `mem[cnt]` <= `PUSH_data`; `cnt` increments.
  - full: the push is dropped; memory and `cnt` are unchanged; `STACK_OVF` is set.
- Pop only:
  - not empty: `cnt` decrements; memory is untouched.
  - empty: the pop is ignored; `STACK_UNF` is set.
- Push and pop together:
  - not empty: replace the top entry, `mem[cnt-1]` <= `PUSH_data`; `cnt` is unchanged. This covers a tail-call or return-then-call sequence. No error, even when full.
  - empty: behaves as push only (`cnt` becomes 1); `STACK_UNF` is set.
- `ERR_CLR` clears both sticky flags. An error event in the same cycle as `ERR_CLR` wins: the flag is set.
- `rst`: `cnt` <= 0, `STACK_OVF`/`STACK_UNF` <= 0. Memory contents are not reset. Reset takes priority over every input, including mid-sequence push/pop.
- Width rules: `cnt` is `$clog2(DEPTH)+1` bits and never wraps. Pointer arithmetic is guarded by the full/empty checks, never by modulo.

## Timing
- Reset values: `POP_output`=0, `STACK_EMPTY`=1, `STACK_FULL`=0, `STACK_COUNT`=0, `STACK_OVF`=0, `STACK_UNF`=0.
- Pop latency 0: `POP_output` is valid during the cycle `STACK_POP` is asserted, and the decider consumes it in that cycle. After the edge, `POP_output` shows the new top.
- Push latency 1: a pushed value appears on `POP_output` the cycle after the push edge.
- Status outputs (`EMPTY`, `FULL`, `COUNT`) are derived combinationally from `cnt`, so they change one cycle after the causing strobe.
- Sticky flags become visible the cycle after the offending strobe.
- No combinational path runs from `STACK_PUSH`/`STACK_POP`/`PUSH_data` to any output.

## Configuration
- `RETURN_STACK_ERR_FLAGS_EN`:
  - Defined: `STACK_OVF`/`STACK_UNF` sticky logic and `ERR_CLR` are implemented as described above.
  - Undefined: both flags are tied to 0 and `ERR_CLR` is ignored. The port list is unchanged. Dropped-push and ignored-pop behaviour is identical in both builds.

## Test plan
- Reset, then push 0x0010, 0x0020, 0x0030 on consecutive cycles -> `STACK_COUNT`=3, `POP_output`=0x0030; pop three times -> `POP_output` reads 0x0020, 0x0010, 0x0000 in turn, and `STACK_EMPTY`=1.
- Push 8 values 0x0100..0x0107 -> `STACK_FULL`=1; push 0x0BAD -> dropped, `POP_output`=0x0107, `STACK_OVF`=1 (macro on) or 0 (macro off).
- From empty, pop -> `STACK_COUNT` stays 0, `POP_output`=0, `STACK_UNF`=1; assert `ERR_CLR` -> flag returns to 0 next cycle.
- With top 0x0020 and count 2, assert push 0x0055 and pop together -> count stays 2, `POP_output`=0x0055, no error; repeat when full -> no `STACK_OVF`.
- Push two values, assert `rst` in the same cycle as a push of 0x0077 -> `STACK_COUNT`=0, `STACK_EMPTY`=1, flags 0; next push of 0x0042 -> `POP_output`=0x0042.
- Random push/pop mix over 2000 cycles checked against a reference model queue -> `POP_output`, `STACK_COUNT` and both flags match every cycle.
